uart_reg_bridge: RTL and testbench

- Register-level command decoder between the UART byte receiver/transmitter and the R-peak detection core.
- Parses host command bytes, assembles 11-bit ECG samples from DINL/DINH writes, and buffers them toward the algorithm.
- Buffers detected R-peak sample indices and serves them back through DOUTL/DOUTM/DOUTH reads, with CR/SR control and status.

---
 rtl/uart_pkg.sv | 35 +++
 rtl/sync_fifo.sv | 60 ++++++
 rtl/uart_reg_bridge.sv | 199 +++++++++++++++++++
 tb/tb_uart_reg_bridge.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART register bridge.
// Register offsets, CR/SR layouts and FSM states.
package uart_pkg;

  localparam logic [2:0] UART_CR_OFFSET    = 3'd0;
  localparam logic [2:0] UART_SR_OFFSET    = 3'd1;
  localparam logic [2:0] UART_DINL_OFFSET  = 3'd2;
  localparam logic [2:0] UART_DINH_OFFSET  = 3'd3;
  localparam logic [2:0] UART_DOUTL_OFFSET = 3'd4;
  localparam logic [2:0] UART_DOUTM_OFFSET = 3'd5;
  localparam logic [2:0] UART_DOUTH_OFFSET = 3'd6;

  typedef struct packed {
    logic rsvd;
    logic proto_err;
    logic result_ovf;
    logic sample_ovf;
    logic tx_fifo_full;
    logic tx_fifo_empty;
    logic rx_fifo_full;
    logic rx_fifo_empty;
  } uart_sr_t;

  typedef struct packed {
    logic clear;
    logic enable;
  } uart_cr_t;

  typedef enum logic [1:0] {
    S_CMD   = 2'd0,
    S_WDATA = 2'd1,
    S_RESP  = 2'd2
  } uart_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, first-word fall-through.
// A push into a full FIFO succeeds only when a pop lands on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = cnt == CW'(DEPTH);
  assign empty   = cnt == '0;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];
  assign count   = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push && !clr) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/uart_reg_bridge.sv
// Host command decoder between the UART byte link and the R-peak core.
// Assembles ECG samples from DINL/DINH and serves R-peak indices back.
module uart_reg_bridge
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH        = 11,
  parameter int CTR_WIDTH         = 22,
  parameter int DATA_OFFSET       = 1024,
  parameter int SAMPLE_FIFO_DEPTH = 16,
  parameter int RESULT_FIFO_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_valid,
  output logic [7:0]                   tx_data,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic signed [DATA_WIDTH-1:0] sample_out,
  output logic                         sample_valid,
  input  logic                         sample_ready,
  input  logic [CTR_WIDTH-1:0]         rpeak_loc,
  input  logic                         rpeak_valid
);

  localparam int SCW = $clog2(SAMPLE_FIFO_DEPTH) + 1;
  localparam int RCW = $clog2(RESULT_FIFO_DEPTH) + 1;
  localparam logic [DATA_WIDTH-1:0] OFS = DATA_WIDTH'(DATA_OFFSET);

  uart_state_e state_q;
  uart_state_e state_d;
  uart_cr_t    cr_q;
  uart_sr_t    sr;

  logic [2:0]  addr_q;
  logic [2:0]  cmd_addr;
  logic [7:0]  dinl_q;
  logic [7:0]  tx_data_q;
  logic [7:0]  rd_byte;
  logic [23:0] head;
  logic        head_vld;
  logic        pop_pend_q;
  logic        proto_err_q;
  logic        result_ovf_q;
  logic        sample_ovf_q;

  logic        cmd_ok;
  logic        cmd_fire;
  logic        rd_latch;
  logic        wr_fire;
  logic        hs;
  logic        proto_set;
  logic        cr_we;
  logic        dinl_we;
  logic        sample_push;
  logic        sample_pop;
  logic        result_pop;
  logic        s_ovf_set;
  logic        r_ovf_set;

  logic [DATA_WIDTH-1:0] code;
  logic [DATA_WIDTH-1:0] s_head;
  logic [CTR_WIDTH-1:0]  r_head;
  logic                  s_full;
  logic                  s_empty;
  logic                  r_full;
  logic                  r_empty;
  logic [SCW-1:0]        s_count;
  logic [RCW-1:0]        r_count;

  assign cmd_ok   = rx_data[7:4] == 4'h0;
  assign cmd_addr = rx_data[3:1];
  assign code     = DATA_WIDTH'({rx_data, dinl_q});
  assign tx_data  = tx_data_q;

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (SAMPLE_FIFO_DEPTH)
  ) u_sample_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cr_q.clear),
    .push  (sample_push),
    .pop   (sample_pop),
    .din   (code - OFS),
    .dout  (s_head),
    .full  (s_full),
    .empty (s_empty),
    .count (s_count)
  );

  sync_fifo #(
    .WIDTH (CTR_WIDTH),
    .DEPTH (RESULT_FIFO_DEPTH)
  ) u_result_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cr_q.clear),
    .push  (rpeak_valid),
    .pop   (result_pop),
    .din   (rpeak_loc),
    .dout  (r_head),
    .full  (r_full),
    .empty (r_empty),
    .count (r_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_CMD;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_CMD:   if (rx_valid && cmd_ok)
                 state_d = rx_data[0] ? S_WDATA : S_RESP;
      S_WDATA: if (rx_valid) state_d = S_CMD;
      S_RESP:  if (tx_ready) state_d = S_CMD;
      default: state_d = S_CMD;
    endcase
  end

  always_comb begin
    tx_valid     = state_q == S_RESP;
    hs           = tx_valid && tx_ready;
    cmd_fire     = state_q == S_CMD && rx_valid && cmd_ok;
    rd_latch     = cmd_fire && !rx_data[0];
    wr_fire      = state_q == S_WDATA && rx_valid;
    cr_we        = wr_fire && addr_q == UART_CR_OFFSET;
    dinl_we      = wr_fire && addr_q == UART_DINL_OFFSET;
    sample_push  = wr_fire && addr_q == UART_DINH_OFFSET
                   && cr_q.enable;
    proto_set    = rx_valid && ((state_q == S_CMD && !cmd_ok)
                   || state_q == S_RESP);
    result_pop   = hs && pop_pend_q;
    sample_valid = s_count != '0 && cr_q.enable;
    sample_pop   = sample_valid && sample_ready;
    s_ovf_set    = sample_push && s_full && !sample_pop;
    r_ovf_set    = rpeak_valid && r_full && !result_pop;
    sample_out   = sample_valid ? s_head : '0;
  end

  // A read landing on the clear cycle sees the FIFO as already flushed
  always_comb begin
    head_vld         = r_count != '0 && !cr_q.clear;
    head             = head_vld ? 24'(r_head) : 24'h0;
    sr.rsvd          = 1'b0;
    sr.proto_err     = proto_err_q;
    sr.result_ovf    = result_ovf_q;
    sr.sample_ovf    = sample_ovf_q;
    sr.tx_fifo_full  = r_full;
    sr.tx_fifo_empty = r_empty;
    sr.rx_fifo_full  = s_full;
    sr.rx_fifo_empty = s_empty;
    rd_byte          = 8'h00;
    unique case (1'b1)
      cmd_addr == UART_CR_OFFSET:    rd_byte = {6'b0, cr_q};
      cmd_addr == UART_SR_OFFSET:    rd_byte = sr;
      cmd_addr == UART_DOUTL_OFFSET: rd_byte = head[7:0];
      cmd_addr == UART_DOUTM_OFFSET: rd_byte = head[15:8];
      cmd_addr == UART_DOUTH_OFFSET: rd_byte = head[23:16];
      default:                       rd_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q       <= '0;
      cr_q.clear   <= 1'b0;
      cr_q.enable  <= 1'b1;
      dinl_q       <= '0;
      tx_data_q    <= '0;
      pop_pend_q   <= 1'b0;
      proto_err_q  <= 1'b0;
      result_ovf_q <= 1'b0;
      sample_ovf_q <= 1'b0;
    end else begin
      if (cmd_fire) addr_q <= cmd_addr;
      if (rd_latch) begin
        tx_data_q  <= rd_byte;
        pop_pend_q <= cmd_addr == UART_DOUTH_OFFSET && head_vld;
      end
      cr_q.clear <= cr_we && rx_data[1];
      if (cr_we)   cr_q.enable <= rx_data[0];
      if (dinl_we) dinl_q <= rx_data;
      if (cr_q.clear) begin
        proto_err_q  <= 1'b0;
        result_ovf_q <= 1'b0;
        sample_ovf_q <= 1'b0;
      end else begin
        if (proto_set) proto_err_q  <= 1'b1;
        if (r_ovf_set) result_ovf_q <= 1'b1;
        if (s_ovf_set) sample_ovf_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Directed and randomized bench for uart_reg_bridge.
// Queue-based register model; monitor scoreboards delivered samples.
module tb_uart_reg_bridge;

  localparam int DW = 11;
  localparam int CW = 22;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [7:0]           rx_data = 8'h00;
  logic                 rx_valid = 1'b0;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_ready = 1'b0;
  logic signed [DW-1:0] sample_out;
  logic                 sample_valid;
  logic                 sample_ready = 1'b0;
  logic [CW-1:0]        rpeak_loc = '0;
  logic                 rpeak_valid = 1'b0;

  int checks = 0;
  int failures = 0;
  int n_got = 0;
  int m_pushed = 0;
  logic [DW-1:0] last_got = '0;

  logic [DW-1:0] mq[$];
  logic [CW-1:0] rq[$];
  logic          m_en = 1'b1;
  logic          m_proto = 1'b0;
  logic          m_sovf = 1'b0;
  logic          m_rovf = 1'b0;
  logic [7:0]    m_dinl = 8'h00;

  always #5 clk = ~clk;

  uart_reg_bridge dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .rpeak_loc    (rpeak_loc),
    .rpeak_valid  (rpeak_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_sr();
    return {1'b0, m_proto, m_rovf, m_sovf,
            rq.size() == 8, rq.size() == 0,
            mq.size() == 16, mq.size() == 0};
  endfunction

  function automatic logic [7:0] exp_byte(input logic [2:0] a);
    logic [23:0] h;
    h = (rq.size() > 0) ? 24'(rq[0]) : 24'h0;
    case (a)
      3'd0:    return {7'b0, m_en};
      3'd1:    return m_sr();
      3'd4:    return h[7:0];
      3'd5:    return h[15:8];
      3'd6:    return h[23:16];
      default: return 8'h00;
    endcase
  endfunction

  task automatic m_reset();
    mq.delete();
    rq.delete();
    m_en = 1'b1;
    m_proto = 1'b0;
    m_sovf = 1'b0;
    m_rovf = 1'b0;
    m_dinl = 8'h00;
  endtask

  task automatic m_write(input logic [2:0] a, input logic [7:0] d);
    logic [DW-1:0] c;
    case (a)
      3'd0: begin
        m_en = d[0];
        if (d[1]) begin
          mq.delete();
          rq.delete();
          m_proto = 1'b0;
          m_sovf = 1'b0;
          m_rovf = 1'b0;
        end
      end
      3'd2: m_dinl = d;
      3'd3: if (m_en) begin
        c = {d[2:0], m_dinl};
        if (mq.size() < 16) begin
          mq.push_back(c - 11'd1024);
          m_pushed++;
        end else m_sovf = 1'b1;
      end
      default: ;
    endcase
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    send_byte({4'h0, a, 1'b1});
    m_write(a, d);
    send_byte(d);
  endtask

  task automatic m_rpeak(input logic [CW-1:0] loc);
    if (rq.size() < 8) rq.push_back(loc);
    else m_rovf = 1'b1;
  endtask

  task automatic pulse(input logic [CW-1:0] loc);
    @(negedge clk);
    rpeak_loc = loc;
    rpeak_valid = 1'b1;
    @(negedge clk);
    rpeak_valid = 1'b0;
    m_rpeak(loc);
  endtask

  task automatic read_chk(input string tag, input logic [2:0] a,
                          output logic [7:0] d, input logic poke,
                          input logic inj, input logic [CW-1:0] loc);
    logic [7:0] exp;
    int k;
    exp = exp_byte(a);
    send_byte({4'h0, a, 1'b0});
    k = 0;
    while (!tx_valid && k < 8) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_txv"}, 32'(tx_valid), 32'd1);
    if (poke) begin
      send_byte(8'h05);
      m_proto = 1'b1;
      check({tag, "_hold_v"}, 32'(tx_valid), 32'd1);
      check({tag, "_hold_d"}, 32'(tx_data), 32'(exp));
    end
    d = tx_data;
    check(tag, 32'(d), 32'(exp));
    tx_ready = 1'b1;
    if (inj) begin
      rpeak_loc = loc;
      rpeak_valid = 1'b1;
    end
    @(negedge clk);
    tx_ready = 1'b0;
    rpeak_valid = 1'b0;
    check({tag, "_one"}, 32'(tx_valid), 32'd0);
    if (a == 3'd6 && rq.size() > 0) void'(rq.pop_front());
    if (inj) m_rpeak(loc);
  endtask

  task automatic rd(input string tag, input logic [2:0] a,
                    output logic [7:0] d);
    read_chk(tag, a, d, 1'b0, 1'b0, '0);
  endtask

  task automatic wr_sample(input logic [DW-1:0] c);
    wr(3'd2, c[7:0]);
    wr(3'd3, {5'($urandom), c[10:8]});
  endtask

  // Scoreboard: each pop is sampled just before the edge that takes it
  initial forever begin
    @(negedge clk);
    #4;
    if (rst_n && sample_valid) begin
      check("valid_when_enabled", 32'(m_en), 32'd1);
      if (sample_ready) begin
        n_got++;
        last_got = sample_out;
        check("sample_expected", 32'(mq.size() > 0), 32'd1);
        if (mq.size() > 0) begin
          check("sample_out", 32'(last_got), 32'(mq[0]));
          void'(mq.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d;
    logic [DW-1:0] c;
    int base;

    repeat (3) @(negedge clk);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_sample_valid", 32'(sample_valid), 32'd0);
    check("rst_sample_out", 32'(sample_out), 32'd0);
    rst_n = 1'b1;
    rd("sr_reset", 3'd1, d);
    check("sr_reset_lit", 32'(d), 32'h05);
    rd("cr_reset", 3'd0, d);
    check("cr_reset_lit", 32'(d), 32'h01);

    sample_ready = 1'b1;
    wr(3'd2, 8'hF3);
    wr(3'd3, 8'h03);
    repeat (3) @(negedge clk);
    check("t1_count", 32'(n_got), 32'd1);
    check("t1_value", 32'(last_got), 32'h7F3);

    for (int i = 0; i < 10; i++) begin
      case (i)
        0:       c = 11'd0;
        1:       c = 11'd1024;
        2:       c = 11'd2047;
        default: c = 11'($urandom);
      endcase
      wr_sample(c);
    end
    repeat (3) @(negedge clk);
    check("stream_count", 32'(n_got), 32'(m_pushed));

    pulse(22'h2A5C31);
    rd("doutl", 3'd4, d);
    check("doutl_lit", 32'(d), 32'h31);
    rd("doutm", 3'd5, d);
    check("doutm_lit", 32'(d), 32'h5C);
    rd("douth", 3'd6, d);
    check("douth_lit", 32'(d), 32'h2A);
    rd("sr_after_pop", 3'd1, d);
    check("sr_tx_empty", 32'(d[2]), 32'd1);

    for (int i = 0; i < 8; i++) pulse(22'($urandom));
    rd("sr_rfull", 3'd1, d);
    read_chk("douth_inj", 3'd6, d, 1'b0, 1'b1, 22'($urandom));
    rd("sr_full_no_ovf", 3'd1, d);
    pulse(22'($urandom));
    rd("sr_rovf", 3'd1, d);
    for (int i = 0; i < 8; i++) begin
      rd("drain_l", 3'd4, d);
      rd("drain_m", 3'd5, d);
      rd("drain_h", 3'd6, d);
    end
    rd("douth_empty", 3'd6, d);
    check("douth_empty_lit", 32'(d), 32'h00);
    rd("reserved", 3'd7, d);

    sample_ready = 1'b0;
    for (int i = 0; i < 17; i++) wr_sample(11'($urandom));
    rd("sr_sovf", 3'd1, d);
    wr(3'd0, 8'h03);
    rd("sr_clr", 3'd1, d);
    check("sr_clr_lit", 32'(d), 32'h05);
    rd("cr_after_clr", 3'd0, d);
    check("cr_after_clr_lit", 32'(d), 32'h01);

    wr(3'd0, 8'h00);
    sample_ready = 1'b1;
    base = n_got;
    wr_sample(11'($urandom));
    repeat (3) @(negedge clk);
    rd("sr_disabled", 3'd1, d);
    check("disabled_rx_empty", 32'(d[0]), 32'd1);
    check("disabled_none", 32'(n_got), 32'(base));
    wr(3'd0, 8'h01);
    wr_sample(11'($urandom));
    repeat (3) @(negedge clk);
    check("reenabled_one", 32'(n_got), 32'(base + 1));

    send_byte(8'h83);
    m_proto = 1'b1;
    rd("sr_bad_cmd", 3'd1, d);
    check("bad_cmd_bit6", 32'(d[6]), 32'd1);
    wr(3'd0, 8'h03);
    rd("sr_clr2", 3'd1, d);
    check("sr_clr2_lit", 32'(d), 32'h05);
    read_chk("sr_poke", 3'd1, d, 1'b1, 1'b0, '0);
    rd("sr_after_poke", 3'd1, d);
    check("sr_after_poke_lit", 32'(d), 32'h45);

    sample_ready = 1'b0;
    wr_sample(11'($urandom));
    pulse(22'($urandom));
    send_byte(8'h07);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
    check("mid_rst_tx_data", 32'(tx_data), 32'd0);
    check("mid_rst_sv", 32'(sample_valid), 32'd0);
    check("mid_rst_so", 32'(sample_out), 32'd0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    base = n_got;
    send_byte(8'h03);
    send_byte(8'h00);
    rd("sr_post_rst", 3'd1, d);
    check("sr_post_rst_lit", 32'(d), 32'h05);
    sample_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_no_sample", 32'(n_got), 32'(base));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
